// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator: FSM encoding, matrix size
// and the key-index field layout {row_idx, col_idx}.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  localparam int KEY_ROW_HI = 3;
  localparam int KEY_ROW_LO = 2;
  localparam int KEY_COL_HI = 1;
  localparam int KEY_COL_LO = 0;

  typedef enum logic [2:0] {
    KS_IDLE      = 3'd0,
    KS_PRESS_BNC = 3'd1,
    KS_HOLD      = 3'd2,
    KS_REL_BNC   = 3'd3,
    KS_GAP       = 3'd4
  } keypad_state_e;

  function automatic logic [1:0] key_row(input logic [3:0] key);
    return key[KEY_ROW_HI:KEY_ROW_LO];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return key[KEY_COL_HI:KEY_COL_LO];
  endfunction

endpackage

// File: rtl/keypad_bounce_timer.sv
// Bounce pacing: a step counter that wraps every STEP cycles and a toggle
// counter that ends the phase after TOGGLES wraps. Shared by both bounce phases.
module keypad_bounce_timer
  import keypad_pkg::*;
#(
  parameter logic [15:0] STEP    = 16'd50,
  parameter logic [7:0]  TOGGLES = 8'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_toggle,
  output logic o_finished
);

  logic        r_active;
  logic [15:0] r_step;
  logic [7:0]  r_tog;
  logic        w_step_end;
  logic        w_last_tog;

  assign w_step_end = (r_step == STEP - 16'd1);
  assign w_last_tog = (r_tog == TOGGLES - 8'd1);
  assign o_toggle   = r_active && w_step_end;
  assign o_finished = o_toggle && w_last_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_step   <= '0;
      r_tog    <= '0;
    end else if (i_clear) begin
      r_active <= 1'b0;
      r_step   <= '0;
      r_tog    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_step   <= '0;
      r_tog    <= '0;
    end else if (r_active) begin
      if (w_step_end) begin
        r_step <= '0;
        r_tog  <= r_tog + 8'd1;
        // The final wrap stops the timer; the owner moves on in the same edge.
        if (w_last_tog) r_active <= 1'b0;
      end else begin
        r_step <= r_step + 16'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_emu.sv
// 4x4 matrix-keypad emulator: accepts timed press requests, closes the chosen
// contact with programmable bounce and answers the scanner's active-low rows.
module keypad_emu
  import keypad_pkg::*;
#(
  parameter logic [15:0] BOUNCE_STEP    = 16'd50,
  parameter logic [7:0]  BOUNCE_TOGGLES = 8'd4,
  parameter logic [23:0] GAP_CYCLES     = 24'd100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                press_valid,
  output logic                press_ready,
  input  logic [3:0]          press_key,
  input  logic [23:0]         press_hold,
  input  logic [KEY_ROWS-1:0] row,
  output logic [KEY_COLS-1:0] col,
  output logic                contact,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] ST_IDLE      = KS_IDLE;
  localparam logic [2:0] ST_PRESS_BNC = KS_PRESS_BNC;
  localparam logic [2:0] ST_HOLD      = KS_HOLD;
  localparam logic [2:0] ST_REL_BNC   = KS_REL_BNC;
  localparam logic [2:0] ST_GAP       = KS_GAP;
  localparam logic       HAS_BOUNCE   = (BOUNCE_TOGGLES != 8'd0);

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic                r_contact;
  logic                w_contact_next;
  logic                r_done;
  logic                w_done_next;
  logic [3:0]          r_key;
  logic [23:0]         r_hold;
  logic [23:0]         r_time;
  logic [KEY_COLS-1:0] r_col;
  logic [KEY_COLS-1:0] w_col_next;
  logic                w_accept;
  logic [23:0]         w_hold_len;
  logic                w_hold_end;
  logic                w_gap_end;
  logic                w_bnc_start;
  logic                w_bnc_tog;
  logic                w_bnc_fin;
  logic                w_row_hit;

  assign press_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign contact     = r_contact;
  assign col         = r_col;
  assign done        = r_done;

  assign w_accept   = press_valid && (r_state == ST_IDLE);
  assign w_hold_len = (press_hold == 24'd0) ? 24'd1 : press_hold;
  assign w_hold_end = (r_time == r_hold - 24'd1);
  assign w_gap_end  = (r_time == GAP_CYCLES - 24'd1);

  keypad_bounce_timer #(
    .STEP    (BOUNCE_STEP),
    .TOGGLES (BOUNCE_TOGGLES)
  ) u_bounce (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_bnc_start),
    .i_clear    (w_bnc_fin),
    .o_toggle   (w_bnc_tog),
    .o_finished (w_bnc_fin)
  );

  always_comb begin
    w_state_next   = r_state;
    w_contact_next = r_contact;
    w_done_next    = 1'b0;
    w_bnc_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_contact_next = 1'b1;
          w_bnc_start    = HAS_BOUNCE;
          w_state_next   = HAS_BOUNCE ? ST_PRESS_BNC : ST_HOLD;
        end
      end
      ST_PRESS_BNC: begin
        if (w_bnc_tog) w_contact_next = ~r_contact;
        if (w_bnc_fin) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_hold_end) begin
          w_contact_next = 1'b0;
          w_bnc_start    = HAS_BOUNCE;
          w_state_next   = HAS_BOUNCE ? ST_REL_BNC : ST_GAP;
        end
      end
      ST_REL_BNC: begin
        if (w_bnc_tog) w_contact_next = ~r_contact;
        if (w_bnc_fin) w_state_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_contact_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_contact <= w_contact_next;
      r_done    <= w_done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key  <= '0;
      r_hold <= 24'd1;
    end else if (w_accept) begin
      r_key  <= press_key;
      r_hold <= w_hold_len;
    end
  end

  // Phase timer restarts on every state change so each phase counts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time <= '0;
    end else if (w_state_next != r_state) begin
      r_time <= '0;
    end else if (r_state == ST_HOLD || r_state == ST_GAP) begin
      r_time <= r_time + 24'd1;
    end
  end

  // Only the selected row matters, so several low rows still let the key answer.
  assign w_row_hit = r_contact && !row[key_row(r_key)];

  generate
    for (genvar gi = 0; gi < KEY_COLS; gi++) begin : g_col
      assign w_col_next[gi] = ~(w_row_hit && (key_col(r_key) == 2'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '1;
    end else begin
      r_col <= w_col_next;
    end
  end

endmodule
